io_timer_irq: RTL and testbench

Memory-mapped timer and interrupt-controller peripheral that answers the J1 core's IO bus (io_rd / io_wr / io_addr / io_dout / io_din) and drives the core's interrupt_request input. It provides:
- a prescaled free-running tick counter;
- a countdown timer with optional auto-reload;
- an 8-bit pending/mask interrupt controller fed by timer events, software sets and synchronized external edge inputs.

It is the responder end of the CPU IO bus, instantiated beside the core in each board top level.

---
 rtl/io_timer_irq.sv | 139 +++++++++++++
 tb/tb_io_timer_irq.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_timer_irq.sv
// J1 IO-bus timer and interrupt controller: prescaled tick counter, countdown
// timer with optional auto-reload, and an 8-bit pending/mask interrupt block.
module io_timer_irq #(
    parameter logic [15:0] BASE     = 16'h0100,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    input  logic [3:0]  ext_irq,
    output logic        interrupt_request
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   ticks_q, ticks_d;
    logic [15:0]   reload_q, reload_d;
    logic [15:0]   count_q, count_d;
    logic          en_q, en_d;
    logic          ar_q, ar_d;
    logic [7:0]    pend_q, pend_d;
    logic [7:0]    mask_q, mask_d;
    logic          irq_q, irq_d;
    logic [15:0]   din_q, din_d;
    logic [3:0]    sync1_q, sync2_q, prev_q;

    logic          sel;
    logic [2:0]    idx;
    logic [7:0]    we;
    logic          tick;
    logic          underflow;
    logic          wrap;
    logic [3:0]    rise;
    logic [7:0]    pend_set;
    logic [7:0]    pend_clr;
    logic [15:0]   rd_data;
    logic          unused_addr0;

    assign unused_addr0 = io_addr[0];
    assign sel  = (io_addr[15:4] == BASE[15:4]);
    assign idx  = io_addr[3:1];
    assign we   = (io_wr && sel) ? (8'd1 << idx) : 8'd0;
    assign tick = (presc_q == PRESC_LAST);
    assign rise = sync2_q & ~prev_q;

    // Underflow fires on the strobe that finds COUNT already at zero.
    assign underflow = tick & en_q & (count_q == 16'd0);
    // A CPU write to TICKS owns the counter this cycle, so no wrap event.
    assign wrap      = tick & (ticks_q == 16'hFFFF) & ~we[0];
    assign pend_set  = {rise, 2'b00, wrap, underflow} | (we[6] ? io_dout[7:0] : 8'd0);
    assign pend_clr  = we[4] ? io_dout[7:0] : 8'd0;

    always_comb begin
        rd_data = 16'd0;
        case (idx)
            3'd0: rd_data = ticks_q;
            3'd1: rd_data = reload_q;
            3'd2: rd_data = count_q;
            3'd3: rd_data = {14'd0, ar_q, en_q};
            3'd4: rd_data = {8'd0, pend_q};
            3'd5: rd_data = {8'd0, mask_q};
            3'd6: rd_data = 16'd0;
            3'd7: rd_data = {12'd0, sync2_q};
        endcase
    end

    always_comb begin
        presc_d  = tick ? '0 : presc_q + 1'b1;
        ticks_d  = ticks_q;
        reload_d = reload_q;
        count_d  = count_q;
        en_d     = en_q;
        ar_d     = ar_q;
        mask_d   = mask_q;
        din_d    = din_q;

        if (tick) ticks_d = ticks_q + 16'd1;
        if (tick && en_q) begin
            if (count_q != 16'd0) count_d = count_q - 16'd1;
            else if (ar_q)        count_d = reload_q;
        end
        if (underflow && !ar_q) en_d = 1'b0;

        if (we[0]) ticks_d  = io_dout;
        if (we[1]) reload_d = io_dout;
        if (we[2]) count_d  = io_dout;
        if (we[3]) begin
            en_d = io_dout[0];
            ar_d = io_dout[1];
        end
        if (we[5]) mask_d = io_dout[7:0];

        // Sets win over a W1C clear of the same bit.
        pend_d = (pend_q & ~pend_clr) | pend_set;
        irq_d  = |(pend_q & mask_q);

        if (io_rd) din_d = sel ? rd_data : 16'd0;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            presc_q  <= '0;
            ticks_q  <= 16'd0;
            reload_q <= 16'd0;
            count_q  <= 16'd0;
            en_q     <= 1'b0;
            ar_q     <= 1'b0;
            pend_q   <= 8'd0;
            mask_q   <= 8'd0;
            irq_q    <= 1'b0;
            din_q    <= 16'd0;
            sync1_q  <= 4'd0;
            sync2_q  <= 4'd0;
            prev_q   <= 4'd0;
        end else begin
            presc_q  <= presc_d;
            ticks_q  <= ticks_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            en_q     <= en_d;
            ar_q     <= ar_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
            din_q    <= din_d;
            sync1_q  <= ext_irq;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
        end
    end

    assign io_din            = din_q;
    assign interrupt_request = irq_q;
endmodule

// File: tb/tb_io_timer_irq.sv
// Bench for io_timer_irq: directed scenarios plus randomized bus traffic,
// checked against a cycle-level behavioural model of the register map.
module tb_io_timer_irq;
    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] io_addr = 16'd0;
    logic [15:0] io_dout = 16'd0;
    logic [3:0]  ext_irq = 4'd0;
    logic [15:0] din0, din1;
    logic        irq0, irq1;
    logic [3:0]  ext_lvl = 4'd0;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    io_timer_irq #(.BASE(16'h0100), .PRESCALE(1)) u_dut (
        .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr),
        .io_addr(io_addr), .io_dout(io_dout), .io_din(din0),
        .ext_irq(ext_irq), .interrupt_request(irq0)
    );

    io_timer_irq #(.BASE(16'h0100), .PRESCALE(3)) u_dut3 (
        .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr),
        .io_addr(io_addr), .io_dout(io_dout), .io_din(din1),
        .ext_irq(ext_irq), .interrupt_request(irq1)
    );

    typedef struct packed {
        logic [15:0] ticks;
        logic [15:0] reload;
        logic [15:0] count;
        logic        en;
        logic        ar;
        logic [7:0]  pend;
        logic [7:0]  mask;
        logic        irq;
        logic [15:0] din;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  prev;
        logic [15:0] pre;
    } mstate_t;

    mstate_t m0, m1;

    // One clock of the peripheral as the register map describes it.
    function automatic mstate_t step(input mstate_t s, input int p, input logic rd,
                                     input logic wr, input logic [15:0] addr,
                                     input logic [15:0] dout, input logic [3:0] ext);
        mstate_t n;
        logic sel, tick, uf, wrp;
        int idx;
        logic [15:0] rv;
        logic [7:0] setm, clrm;
        n = s;
        sel = (addr[15:4] == 12'h010);
        idx = int'(addr[3:1]);
        case (idx)
            0: rv = s.ticks;
            1: rv = s.reload;
            2: rv = s.count;
            3: rv = {14'd0, s.ar, s.en};
            4: rv = {8'd0, s.pend};
            5: rv = {8'd0, s.mask};
            7: rv = {12'd0, s.s2};
            default: rv = 16'd0;
        endcase
        if (rd) n.din = sel ? rv : 16'd0;
        tick = (int'(s.pre) == p - 1);
        n.pre = tick ? 16'd0 : s.pre + 16'd1;
        uf = tick && s.en && (s.count == 16'd0);
        wrp = tick && (s.ticks == 16'hFFFF) && !(wr && sel && idx == 0);
        if (tick) n.ticks = s.ticks + 16'd1;
        if (tick && s.en) begin
            if (s.count != 16'd0) n.count = s.count - 16'd1;
            else if (s.ar) n.count = s.reload;
        end
        if (uf && !s.ar) n.en = 1'b0;
        if (wr && sel) begin
            case (idx)
                0: n.ticks = dout;
                1: n.reload = dout;
                2: n.count = dout;
                3: begin n.en = dout[0]; n.ar = dout[1]; end
                5: n.mask = dout[7:0];
                default: ;
            endcase
        end
        setm = {s.s2 & ~s.prev, 2'b00, wrp, uf};
        if (wr && sel && idx == 6) setm = setm | dout[7:0];
        clrm = (wr && sel && idx == 4) ? dout[7:0] : 8'd0;
        n.pend = (s.pend & ~clrm) | setm;
        n.irq = |(s.pend & s.mask);
        n.prev = s.s2;
        n.s2 = s.s1;
        n.s1 = ext;
        return n;
    endfunction

    function automatic logic [15:0] ra(input int idx);
        return 16'h0100 | 16'(idx << 1);
    endfunction

    task automatic cycle(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] dout);
        io_rd = rd;
        io_wr = wr;
        io_addr = addr;
        io_dout = dout;
        ext_irq = ext_lvl;
        m0 = step(m0, 1, rd, wr, addr, dout, ext_lvl);
        m1 = step(m1, 3, rd, wr, addr, dout, ext_lvl);
        @(posedge clk);
        #1;
        io_rd = 1'b0;
        io_wr = 1'b0;
    endtask

    task automatic wr_reg(input int idx, input logic [15:0] d);
        cycle(1'b0, 1'b1, ra(idx), d);
    endtask

    task automatic rd_reg(input int idx);
        cycle(1'b1, 1'b0, ra(idx), 16'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic test_reset;
        checks++;
        if (din0 !== 16'd0 || irq0 !== 1'b0) begin
            errors++; $display("FAIL por_state din=%h irq=%b exp 0000/0", din0, irq0);
        end
        resetq = 1'b1;
        m0 = '0; m1 = '0;
        wr_reg(1, 16'd5); wr_reg(2, 16'd5); wr_reg(3, 16'd3);
        wr_reg(5, 16'h0001); wr_reg(6, 16'h0001);
        idle(2);
        checks++;
        if (irq0 !== 1'b1) begin
            errors++; $display("FAIL pre_reset_irq got %b exp 1", irq0);
        end
        rd_reg(5);
        checks++;
        if (din0 !== 16'h0001) begin
            errors++; $display("FAIL pre_reset_mask got %h exp 0001", din0);
        end
        #2 resetq = 1'b0;
        #1;
        checks++;
        if (din0 !== 16'd0 || irq0 !== 1'b0 || din1 !== 16'd0 || irq1 !== 1'b0) begin
            errors++; $display("FAIL reset_async din=%h irq=%b exp 0000/0", din0, irq0);
        end
        @(posedge clk); #1;
        resetq = 1'b1;
        ext_lvl = 4'd0;
        m0 = '0; m1 = '0;
        for (int i = 0; i < 8; i++) begin
            rd_reg(i);
            checks++;
            if (din0 !== 16'd0 || din1 !== 16'd0) begin
                errors++; $display("FAIL reset_reg%0d got %h/%h exp 0000", i, din0, din1);
            end
        end
    endtask

    task automatic test_auto_reload;
        int hi_t[$];
        wr_reg(4, 16'h00FF); wr_reg(5, 16'h0001);
        wr_reg(1, 16'd3); wr_reg(2, 16'd3); wr_reg(3, 16'd3);
        for (int i = 0; i < 16; i++) begin
            wr_reg(4, 16'h0001);
            checks++;
            if (irq0 !== m0.irq || irq1 !== m1.irq) begin
                errors++; $display("FAIL ar_irq cyc%0d got %b/%b exp %b/%b", i, irq0, irq1, m0.irq, m1.irq);
            end
            if (irq0 === 1'b1) hi_t.push_back(i);
        end
        checks++;
        if (hi_t.size() < 3) begin
            errors++; $display("FAIL ar_pulses got %0d exp >=3", hi_t.size());
        end
        for (int i = 1; i < hi_t.size(); i++) begin
            checks++;
            if (hi_t[i] - hi_t[i-1] != 4) begin
                errors++; $display("FAIL ar_period got %0d exp 4", hi_t[i] - hi_t[i-1]);
            end
        end
    endtask

    task automatic test_one_shot;
        wr_reg(3, 16'd0); wr_reg(4, 16'h00FF);
        wr_reg(2, 16'd2); wr_reg(3, 16'h0001);
        idle(6);
        rd_reg(3);
        checks++;
        if (din0 !== 16'h0000) begin
            errors++; $display("FAIL oneshot_ctrl got %h exp 0000", din0);
        end
        rd_reg(2);
        checks++;
        if (din0 !== 16'h0000) begin
            errors++; $display("FAIL oneshot_count got %h exp 0000", din0);
        end
        rd_reg(4);
        checks++;
        if ((din0 & 16'h0001) !== 16'h0001) begin
            errors++; $display("FAIL oneshot_pend got %h exp bit0 set", din0);
        end
        wr_reg(4, 16'h0001);
        idle(6);
        rd_reg(4);
        checks++;
        if ((din0 & 16'h0001) !== 16'h0000 || din1 !== m1.din) begin
            errors++; $display("FAIL oneshot_single got %h/%h exp bit0 clear/%h", din0, din1, m1.din);
        end
    endtask

    task automatic test_ticks_wrap;
        wr_reg(3, 16'd0); wr_reg(4, 16'h00FF); wr_reg(5, 16'h0002);
        wr_reg(0, 16'hFFFE);
        idle(2);
        checks++;
        if (irq0 !== 1'b0) begin
            errors++; $display("FAIL wrap_irq_early got %b exp 0", irq0);
        end
        rd_reg(0);
        checks++;
        if (din0 !== 16'h0000) begin
            errors++; $display("FAIL wrap_ticks got %h exp 0000", din0);
        end
        checks++;
        if (irq0 !== 1'b1) begin
            errors++; $display("FAIL wrap_irq got %b exp 1", irq0);
        end
        rd_reg(4);
        checks++;
        if (din0 !== 16'h0002 || din1 !== m1.din) begin
            errors++; $display("FAIL wrap_pend got %h/%h exp 0002/%h", din0, din1, m1.din);
        end
    endtask

    task automatic test_ext_edge;
        logic [3:0] exp_irq;
        exp_irq = 4'b1000;
        wr_reg(4, 16'h00FF); wr_reg(5, 16'h0040);
        ext_lvl = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            ext_lvl = 4'd0;
            checks++;
            if (irq0 !== exp_irq[i]) begin
                errors++; $display("FAIL ext_irq_E+%0d got %b exp %b", i, irq0, exp_irq[i]);
            end
        end
        rd_reg(4);
        checks++;
        if (din0 !== 16'h0040) begin
            errors++; $display("FAIL ext_pend got %h exp 0040", din0);
        end
        wr_reg(4, 16'h00FF);
        ext_lvl = 4'b0100;
        idle(4);
        wr_reg(4, 16'h0040);
        idle(4);
        rd_reg(4);
        checks++;
        if (din0 !== 16'h0000) begin
            errors++; $display("FAIL ext_level_noset got %h exp 0000", din0);
        end
        rd_reg(7);
        checks++;
        if (din0 !== 16'h0004) begin
            errors++; $display("FAIL ext_extin got %h exp 0004", din0);
        end
        ext_lvl = 4'd0;
        idle(3);
    endtask

    task automatic test_bus;
        wr_reg(5, 16'h005A);
        rd_reg(5);
        checks++;
        if (din0 !== 16'h005A) begin
            errors++; $display("FAIL bus_mask got %h exp 005a", din0);
        end
        cycle(1'b1, 1'b0, 16'h020A, 16'd0);
        checks++;
        if (din0 !== 16'h0000) begin
            errors++; $display("FAIL bus_unsel_rd got %h exp 0000", din0);
        end
        cycle(1'b0, 1'b1, 16'h020A, 16'hFFFF);
        cycle(1'b1, 1'b0, 16'h010B, 16'd0);
        checks++;
        if (din0 !== 16'h005A) begin
            errors++; $display("FAIL bus_unsel_wr got %h exp 005a", din0);
        end
        cycle(1'b1, 1'b1, ra(5), 16'h0033);
        checks++;
        if (din0 !== 16'h005A) begin
            errors++; $display("FAIL bus_rdwr_old got %h exp 005a", din0);
        end
        rd_reg(5);
        checks++;
        if (din0 !== 16'h0033) begin
            errors++; $display("FAIL bus_rdwr_new got %h exp 0033", din0);
        end
        wr_reg(4, 16'h00FF); wr_reg(6, 16'h0008);
        rd_reg(4);
        checks++;
        if (din0 !== 16'h0008) begin
            errors++; $display("FAIL swset got %h exp 0008", din0);
        end
        rd_reg(6);
        checks++;
        if (din0 !== 16'h0000) begin
            errors++; $display("FAIL swset_rd got %h exp 0000", din0);
        end
        wr_reg(3, 16'd0); wr_reg(1, 16'd0); wr_reg(2, 16'd0); wr_reg(3, 16'd3);
        wr_reg(4, 16'h0001);
        rd_reg(4);
        checks++;
        if ((din0 & 16'h0001) !== 16'h0001) begin
            errors++; $display("FAIL set_beats_w1c got %h exp bit0 set", din0);
        end
        wr_reg(2, 16'h0100);
        rd_reg(2);
        checks++;
        if (din0 !== 16'h0100) begin
            errors++; $display("FAIL count_wr_on_uf got %h exp 0100", din0);
        end
        wr_reg(3, 16'd0);
    endtask

    task automatic test_random;
        logic rd, wr;
        logic [15:0] a, d;
        logic [33:0] e;
        int idx;
        exp_q.delete();
        for (int i = 0; i < 600; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 2) == 0);
            idx = $urandom_range(0, 7);
            a = ra(idx) | 16'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 16'h0300 | 16'(idx << 1);
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) d = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) ext_lvl = 4'($urandom_range(0, 15));
            cycle(rd, wr, a, d);
            exp_q.push_back({m1.irq, m1.din, m0.irq, m0.din});
            e = exp_q.pop_front();
            checks++;
            if ({irq1, din1, irq0, din0} !== e) begin
                errors++;
                $display("FAIL rand_cyc%0d got %b/%h %b/%h exp %b/%h %b/%h", i,
                         irq0, din0, irq1, din1, e[16], e[15:0], e[33], e[32:17]);
            end
        end
    endtask

    initial begin
        m0 = '0;
        m1 = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_auto_reload();
        test_one_shot();
        test_ticks_wrap();
        test_ext_edge();
        test_bus();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
